// File: rtl/vending_machine.sv
// ---------------------------------------------------------------------------
// vending_machine
//   Single-product coin dispenser controller. The price is 15 units. Credit
//   builds up in a three-state FSM (0 / 5 / 10). When the credit reaches or
//   passes 15, the block issues a one-cycle registered dispense pulse. No
//   change is returned, so a 10 coin paid on top of 10 credit loses 5 units.
//
// Ports
//   clk   in  1  system clock; all state updates happen on the rising edge
//   rst   in  1  asynchronous reset, active low (0 = held in reset)
//   coin  in  2  coin code sampled each rising edge:
//                00 = none, 01 = 5 units, 11 = 10 units,
//                10 or X = treated as none
//   coke  out 1  dispense pulse, high for exactly one cycle per sale
// ---------------------------------------------------------------------------
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  output logic       coke
);

  localparam logic [1:0] NO_COIN = 2'b00;
  localparam logic [1:0] FIVE    = 2'b01;
  localparam logic [1:0] TEN     = 2'b11;

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   sale;

  // Both the state and the pulse are registered. This keeps coke glitch-free
  // toward the release actuator. It also makes the pulse line up with the
  // edge that accepts the completing coin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
      coke  <= 1'b0;
    end else begin
      state <= state_nxt;
      coke  <= sale;
    end
  end

  // Next-state decode. A coin code other than FIVE or TEN falls into the
  // default arm of the inner case and leaves the credit unchanged. This
  // covers the reserved code 10 and any X or Z value, so a floating
  // acceptor line can never produce a sale.
  always_comb begin
    state_nxt = state;
    sale      = 1'b0;
    case (state)
      S0: begin
        case (coin)
          FIVE:    state_nxt = S5;
          TEN:     state_nxt = S10;
          default: state_nxt = S0;
        endcase
      end
      S5: begin
        case (coin)
          FIVE:    state_nxt = S10;
          TEN: begin
            state_nxt = S0;
            sale      = 1'b1;
          end
          default: state_nxt = S5;
        endcase
      end
      S10: begin
        case (coin)
          // 15 exact, or 20 with the extra 5 forfeited
          FIVE, TEN: begin
            state_nxt = S0;
            sale      = 1'b1;
          end
          default:   state_nxt = S10;
        endcase
      end
      // The unused encoding 2'b11 recovers to the idle state.
      default: begin
        state_nxt = S0;
        sale      = 1'b0;
      end
    endcase
  end

  // NO_COIN is the implicit hold case above. It is named here so the full
  // code set stays visible in one place.
  logic unused_codes;
  assign unused_codes = ^NO_COIN;

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  localparam logic [1:0] NO_COIN = 2'b00;
  localparam logic [1:0] FIVE    = 2'b01;
  localparam logic [1:0] TEN     = 2'b11;
  localparam logic [1:0] BAD     = 2'b10;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       coke;

  int n_checks = 0;
  int n_fails  = 0;

  vending_machine dut (
    .clk  (clk),
    .rst  (rst),
    .coin (coin),
    .coke (coke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic exp);
    n_checks++;
    assert (coke === exp) else begin
      n_fails++;
      $error("FAIL %s: coke observed %b expected %b", tag, coke, exp);
    end
  endtask

  // Drive a coin at the falling edge, then sample 1 time unit after the
  // rising edge that accepts it.
  task automatic step(input string tag, input logic [1:0] c, input logic exp);
    @(negedge clk);
    coin = c;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    coin = TEN;
    #1;
    check("reset_async_no_clock", 1'b0);
    // Coins are ignored while reset is held.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      coin = (i % 2 == 0) ? TEN : NO_COIN;
      @(posedge clk);
      #1;
      check("reset_held_coin_toggle", 1'b0);
    end
    @(negedge clk);
    coin = NO_COIN;
    rst  = 1'b1;

    // Starting from S0, TEN then FIVE completes a sale on the second coin.
    // If the state were S5, the TEN would already sell.
    step("post_reset_ten", TEN, 1'b0);
    step("post_reset_five_sale", FIVE, 1'b1);

    // FIVE, FIVE, FIVE -> 0, 0, 1, then NO_COIN -> 0 and back at S0.
    step("fff_1", FIVE, 1'b0);
    step("fff_2", FIVE, 1'b0);
    step("fff_3_sale", FIVE, 1'b1);
    step("fff_idle", NO_COIN, 1'b0);
    step("fff_s0_ten", TEN, 1'b0);
    step("fff_s0_five_sale", FIVE, 1'b1);

    // TEN, TEN -> sale with the extra 5 forfeited. Then three FIVEs are
    // needed again.
    step("tt_1", TEN, 1'b0);
    step("tt_2_sale", TEN, 1'b1);
    step("tt_five_s5", FIVE, 1'b0);
    step("tt_five_s10", FIVE, 1'b0);
    step("tt_five_sale", FIVE, 1'b1);

    // FIVE, TEN -> sale. Then FIVE plus NO_COIN keeps 5 credit.
    step("ft_1", FIVE, 1'b0);
    step("ft_2_sale", TEN, 1'b1);
    step("hold_five", FIVE, 1'b0);
    step("hold_idle", NO_COIN, 1'b0);
    for (int i = 0; i < 5; i++) step("hold_idle_long", NO_COIN, 1'b0);
    step("hold_ten_sale", TEN, 1'b1);

    // The reserved code in S5 holds the credit.
    step("bad_five", FIVE, 1'b0);
    for (int i = 0; i < 3; i++) step("bad_code_hold", BAD, 1'b0);
    step("bad_ten_sale", TEN, 1'b1);

    // An X coin code also holds the credit.
    step("x_five", FIVE, 1'b0);
    step("x_code_hold", 2'bxx, 1'b0);
    step("x_ten_sale", TEN, 1'b1);

    // Back-to-back sales: the pulses are two cycles apart, and the pulse
    // clears in between.
    step("b2b_ten", TEN, 1'b0);
    step("b2b_ten_sale", TEN, 1'b1);
    step("b2b_five", FIVE, 1'b0);
    step("b2b_ten_sale2", TEN, 1'b1);
    step("b2b_idle", NO_COIN, 1'b0);

    // Async reset while coke is high: the pulse drops before the next edge.
    step("ar_ten", TEN, 1'b0);
    step("ar_ten_sale", TEN, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_coke_drop_async", 1'b0);
    @(negedge clk);
    rst  = 1'b1;
    coin = NO_COIN;

    // Reset in S10 discards the credit.
    step("ar_s10_ten", TEN, 1'b0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    coin = TEN;
    @(posedge clk);
    #1;
    check("ar_s10_held_ignores_coin", 1'b0);
    @(negedge clk);
    coin = NO_COIN;
    rst  = 1'b1;
    step("ar_release_five_s5", FIVE, 1'b0);
    step("ar_release_five_s10", FIVE, 1'b0);
    step("ar_release_five_sale", FIVE, 1'b1);
    step("ar_final_idle", NO_COIN, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
